// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the ID->EX operand-2 sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  // Operand-2 mux selects seen by the EX stage
  localparam logic [1:0] OP2_ZERO  = 2'b00;
  localparam logic [1:0] OP2_RS2   = 2'b01;
  localparam logic [1:0] OP2_ONE   = 2'b10;
  localparam logic [1:0] OP2_THREE = 2'b11;

  // Macro-op class presented by decode
  localparam logic [1:0] MACRO_SINGLE = 2'b00;
  localparam logic [1:0] MACRO_CALL   = 2'b01;
  localparam logic [1:0] MACRO_REPEAT = 2'b10;
  localparam logic [1:0] MACRO_RSVD   = 2'b11;

  // ST_CALL2 / ST_REPEAT mean "more micro-ops of this macro still to emit".
  // The final step of any macro is emitted with the state already back at ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALL2  = 2'b01,
    ST_REPEAT = 2'b10
  } state_t;

endpackage

// File: rtl/op2_rep_counter.sv
// Loadable down-counter holding the remaining REPEAT iterations, with zero flag.
// Latency: load/decrement visible the cycle after they are requested.
// Backpressure: hold freezes the count; clr/rst force it to zero and win over everything.
module op2_rep_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign zero = (cnt == '0);

  // Count register: clear > hold > load > saturating decrement
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/op2_sel_sequencer.sv
// ID->EX sequencer driving Op2_Sel_EX; expands CALL (2 steps) and REPEAT (N steps).
// Latency: first micro-op on Op2_Sel_EX one cycle after id_valid && id_ready.
// Backpressure: id_ready only when the EX step being produced finishes the macro; stall_ex freezes EX.
module op2_sel_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int         CNT_W   = 4,
  parameter logic [1:0] NOP_SEL = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [1:0]       id_macro,
  input  logic [1:0]       id_op2_sel,
  input  logic [CNT_W-1:0] id_count,
  input  logic             stall_ex,
  input  logic             flush,
  output logic [1:0]       Op2_Sel_EX,
  output logic             ex_valid,
  output logic             ex_last,
  output logic             busy,
  output logic             illegal_op
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       sel_d;
  logic             vld_d, last_d, ill_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_q;
  logic             accept;

  // The last step of every macro is emitted from IDLE, so accepting only in IDLE
  // lets the next op's first micro-op follow the current last step with no bubble.
  assign id_ready = !rst && !stall_ex && !flush && (state_q == ST_IDLE);
  assign accept   = id_valid && id_ready;

  // Remaining-iteration counter; count 0 wraps to 2**CNT_W iterations via the -1 load
  op2_rep_counter #(.CNT_W(CNT_W)) u_rep_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .hold     (stall_ex),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt_q),
    .zero     (cnt_zero)
  );

  // Next-state and next EX micro-op
  always_comb begin
    state_d      = ST_IDLE;
    sel_d        = NOP_SEL;
    vld_d        = 1'b0;
    last_d       = 1'b0;
    ill_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = id_count - CNT_ONE;
    case (state_q)
      ST_CALL2: begin
        sel_d  = OP2_ONE;
        vld_d  = 1'b1;
        last_d = 1'b1;
      end
      ST_REPEAT: begin
        sel_d   = OP2_RS2;
        vld_d   = 1'b1;
        cnt_dec = 1'b1;
        // zero only reachable after an abnormal exit; treat it as "finish now"
        if (cnt_q == CNT_ONE || cnt_zero) begin
          last_d = 1'b1;
        end else begin
          state_d = ST_REPEAT;
        end
      end
      default: begin
        if (accept) begin
          vld_d = 1'b1;
          case (id_macro)
            MACRO_SINGLE: begin
              sel_d  = id_op2_sel;
              last_d = 1'b1;
            end
            MACRO_CALL: begin
              sel_d   = OP2_THREE;
              state_d = ST_CALL2;
            end
            MACRO_REPEAT: begin
              sel_d    = OP2_RS2;
              cnt_load = 1'b1;
              if (cnt_load_val == '0) begin
                last_d = 1'b1;
              end else begin
                state_d = ST_REPEAT;
              end
            end
            default: begin
              sel_d  = NOP_SEL;
              last_d = 1'b1;
              ill_d  = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  // State and EX output registers: rst/flush kill, stall holds (illegal_op stays a pulse)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= ST_IDLE;
      Op2_Sel_EX <= NOP_SEL;
      ex_valid   <= 1'b0;
      ex_last    <= 1'b0;
      busy       <= 1'b0;
      illegal_op <= 1'b0;
    end else if (stall_ex) begin
      illegal_op <= 1'b0;
    end else begin
      state_q    <= state_d;
      Op2_Sel_EX <= sel_d;
      ex_valid   <= vld_d;
      ex_last    <= last_d;
      busy       <= (state_d != ST_IDLE);
      illegal_op <= ill_d;
    end
  end

endmodule

// File: tb/tb_op2_sel_sequencer.sv
// Directed bench for op2_sel_sequencer with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_op2_sel_sequencer;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic       id_ready;
  logic [1:0] id_macro;
  logic [1:0] id_op2_sel;
  logic [3:0] id_count;
  logic       stall_ex;
  logic       flush;
  logic [1:0] Op2_Sel_EX;
  logic       ex_valid;
  logic       ex_last;
  logic       busy;
  logic       illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  op2_sel_sequencer #(.CNT_W(4), .NOP_SEL(2'b00)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_macro   (id_macro),
    .id_op2_sel (id_op2_sel),
    .id_count   (id_count),
    .stall_ex   (stall_ex),
    .flush      (flush),
    .Op2_Sel_EX (Op2_Sel_EX),
    .ex_valid   (ex_valid),
    .ex_last    (ex_last),
    .busy       (busy),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance one clock; leave time 1 past the edge so sampling avoids it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [1:0] m, input logic [1:0] s, input logic [3:0] c);
    id_valid   = v;
    id_macro   = m;
    id_op2_sel = s;
    id_count   = c;
    #1;
  endtask

  task automatic ex_is(input string tag, input int sel, input int vld, input int last, input int bsy);
    chk({tag, ".sel"},  32'(Op2_Sel_EX), sel);
    chk({tag, ".vld"},  32'(ex_valid),   vld);
    chk({tag, ".last"}, 32'(ex_last),    last);
    chk({tag, ".busy"}, 32'(busy),       bsy);
  endtask

  initial begin
    logic [1:0] sels [3];
    sels[0] = 2'b01; sels[1] = 2'b10; sels[2] = 2'b11;

    // reset with a valid op offered
    rst = 1'b1; stall_ex = 1'b0; flush = 1'b0;
    offer(1'b1, 2'b00, 2'b11, 4'd0);
    chk("rst.ready", 32'(id_ready), 0);
    cyc();
    chk("rst.ready2", 32'(id_ready), 0);
    cyc();
    ex_is("rst", 0, 0, 0, 0);
    chk("rst.ill", 32'(illegal_op), 0);
    rst = 1'b0;
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    chk("idle.ready", 32'(id_ready), 1);
    cyc();
    ex_is("idle", 0, 0, 0, 0);

    // SINGLE back-to-back, no bubbles
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 2'b00, sels[i], 4'd0);
      chk("single.ready", 32'(id_ready), 1);
      cyc();
      ex_is("single", int'(sels[i]), 1, 1, 0);
    end
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    cyc();
    ex_is("single.drain", 0, 0, 0, 0);

    // CALL then SINGLE(01) offered continuously
    offer(1'b1, 2'b01, 2'b00, 4'd0);
    cyc();
    ex_is("call.s1", 3, 1, 0, 1);
    offer(1'b1, 2'b00, 2'b01, 4'd0);
    chk("call.s1.ready", 32'(id_ready), 0);
    cyc();
    ex_is("call.s2", 2, 1, 1, 0);
    chk("call.s2.ready", 32'(id_ready), 1);
    cyc();
    ex_is("call.next", 1, 1, 1, 0);
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    cyc();
    ex_is("call.drain", 0, 0, 0, 0);

    // REPEAT count 3
    offer(1'b1, 2'b10, 2'b00, 4'd3);
    cyc();
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    for (int i = 0; i < 3; i++) begin
      ex_is("rep3", 1, 1, (i == 2) ? 1 : 0, (i < 2) ? 1 : 0);
      cyc();
    end
    ex_is("rep3.drain", 0, 0, 0, 0);

    // REPEAT count 0 -> 16 iterations
    offer(1'b1, 2'b10, 2'b00, 4'd0);
    cyc();
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    for (int i = 0; i < 16; i++) begin
      chk("rep16.sel",  32'(Op2_Sel_EX), 1);
      chk("rep16.vld",  32'(ex_valid), 1);
      chk("rep16.last", 32'(ex_last), (i == 15) ? 1 : 0);
      cyc();
    end
    ex_is("rep16.drain", 0, 0, 0, 0);

    // REPEAT count 1 acts like SINGLE(01)
    offer(1'b1, 2'b10, 2'b00, 4'd1);
    cyc();
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    ex_is("rep1", 1, 1, 1, 0);
    cyc();
    ex_is("rep1.drain", 0, 0, 0, 0);

    // REPEAT 2 then SINGLE(10) offered continuously: follows last step directly
    offer(1'b1, 2'b10, 2'b00, 4'd2);
    cyc();
    offer(1'b1, 2'b00, 2'b10, 4'd0);
    ex_is("rep2.s1", 1, 1, 0, 1);
    chk("rep2.s1.ready", 32'(id_ready), 0);
    cyc();
    ex_is("rep2.s2", 1, 1, 1, 0);
    chk("rep2.s2.ready", 32'(id_ready), 1);
    cyc();
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    ex_is("rep2.next", 2, 1, 1, 0);
    cyc();

    // stall mid-REPEAT(4) at step 2 for 3 cycles
    offer(1'b1, 2'b10, 2'b00, 4'd4);
    cyc();
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    ex_is("stall.s1", 1, 1, 0, 1);
    cyc();
    ex_is("stall.s2", 1, 1, 0, 1);
    stall_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.ready", 32'(id_ready), 0);
      cyc();
      ex_is("stall.hold", 1, 1, 0, 1);
    end
    stall_ex = 1'b0;
    cyc();
    ex_is("stall.s3", 1, 1, 0, 1);
    cyc();
    ex_is("stall.s4", 1, 1, 1, 0);
    cyc();
    ex_is("stall.drain", 0, 0, 0, 0);

    // flush during CALL step 1
    offer(1'b1, 2'b01, 2'b00, 4'd0);
    cyc();
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    ex_is("flush.call.s1", 3, 1, 0, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    ex_is("flush.call", 0, 0, 0, 0);
    cyc();
    ex_is("flush.call.after", 0, 0, 0, 0);

    // flush together with stall mid-REPEAT, op offered but not taken
    offer(1'b1, 2'b10, 2'b00, 4'd4);
    cyc();
    stall_ex = 1'b1; flush = 1'b1;
    offer(1'b1, 2'b00, 2'b11, 4'd0);
    chk("flushstall.ready", 32'(id_ready), 0);
    cyc();
    stall_ex = 1'b0; flush = 1'b0;
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    ex_is("flushstall", 0, 0, 0, 0);

    // counter was cleared: a fresh REPEAT(2) runs exactly 2 steps
    offer(1'b1, 2'b10, 2'b00, 4'd2);
    cyc();
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    ex_is("post.s1", 1, 1, 0, 1);
    cyc();
    ex_is("post.s2", 1, 1, 1, 0);
    cyc();

    // reserved macro 11
    offer(1'b1, 2'b11, 2'b10, 4'd0);
    cyc();
    offer(1'b0, 2'b00, 2'b00, 4'd0);
    ex_is("rsvd", 0, 1, 1, 0);
    chk("rsvd.ill", 32'(illegal_op), 1);
    cyc();
    ex_is("rsvd.drain", 0, 0, 0, 0);
    chk("rsvd.ill.off", 32'(illegal_op), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
